neuron_acc_ctrl: RTL and testbench

Sequencing controller for the neuron's accumulate datapath. It loads a bias, then steps a shared registered 17+8-bit adder once per accepted input term for exactly N_TERMS terms. After each add it saturates the result back into a 17-bit accumulator and applies an optional ReLU. The final activation is presented on a valid/ready output port. It sits between the weighted-term producer upstream and the neuron output stage downstream.

---
 rtl/neuron_pkg.sv | 35 +++
 rtl/acc_adder_stage.sv | 24 ++
 rtl/neuron_acc_ctrl.sv | 121 ++++++++++++
 tb/tb_neuron_acc_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types, widths and saturation helper for the neuron accumulate path.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, ADD, OUT} state_t;

  localparam int ACC_W   = 17;
  localparam int IN_W    = 8;
  localparam int SUM_W   = 18;
  localparam int ACC_MAX = 65535;
  localparam int ACC_MIN = -65536;

  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(ACC_MAX);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(ACC_MIN);

  typedef struct packed {
    logic             sat;
    logic [ACC_W-1:0] value;
  } sat_res_t;

  // Clip the 18-bit sum into the 17-bit accumulator range and flag clipping.
  function automatic sat_res_t saturate(input logic signed [SUM_W-1:0] s);
    sat_res_t r;
    r.sat   = 1'b0;
    r.value = s[ACC_W-1:0];
    if (s > SUM_MAX) begin
      r.sat   = 1'b1;
      r.value = ACC_W'(ACC_MAX);
    end else if (s < SUM_MIN) begin
      r.sat   = 1'b1;
      r.value = ACC_W'(ACC_MIN);
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_adder_stage.sv
// Registered sign-extending 17+8 -> 18-bit adder, one cycle of latency.
module acc_adder_stage
  import neuron_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ACC_W-1:0] in1,
  input  logic signed [IN_W-1:0]  in2,
  output logic signed [SUM_W-1:0] total
);

  logic signed [SUM_W-1:0] total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else begin
      total_q <= SUM_W'(in1) + SUM_W'(in2);
    end
  end

  assign total = total_q;

endmodule

// File: rtl/neuron_acc_ctrl.sv
// Sequences bias load, N_TERMS saturating accumulations and the optional ReLU
// result onto a valid/ready output port.
module neuron_acc_ctrl
  import neuron_pkg::*;
#(
  parameter int N_TERMS  = 8,
  parameter bit ACT_RELU = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    term_hs;
  logic signed [IN_W-1:0]  add_in2;
  logic signed [SUM_W-1:0] sum;
  sat_res_t                clip;

  // The term is gated to zero outside a handshake so in_data is never used
  // while in_ready is low.
  assign term_hs = (state_q == FETCH) && in_valid;
  assign add_in2 = term_hs ? in_data : '0;

  acc_adder_stage u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (acc_q),
    .in2   (add_in2),
    .total (sum)
  );

  assign clip = saturate(sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (term_hs) begin
          state_d = ADD;
        end
      end
      ADD: begin
        // The adder register holds acc + term launched on the handshake edge.
        acc_d = clip.value;
        sat_d = sat_q | clip.sat;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == LAST_CNT) begin
          out_data_d = (ACT_RELU && clip.value[ACC_W-1]) ? '0 : clip.value;
          out_sat_d  = sat_d;
          state_d    = OUT;
        end else begin
          state_d = FETCH;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == FETCH);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Directed bench for neuron_acc_ctrl: a ReLU and a pass-through instance share
// one stimulus stream with N_TERMS=4.
module tb_neuron_acc_ctrl;

  localparam int NT = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [16:0] bias;
  logic               in_valid;
  logic signed [7:0]  in_data;
  logic               out_ready;

  logic               inReadyP, outValidP, outSatP, busyP;
  logic signed [16:0] outDataP;
  logic               inReadyR, outValidR, outSatR, busyR;
  logic signed [16:0] outDataR;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  neuron_acc_ctrl #(.N_TERMS(NT), .ACT_RELU(1'b0)) dutP (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (inReadyP),
    .out_valid (outValidP),
    .out_data  (outDataP),
    .out_sat   (outSatP),
    .out_ready (out_ready),
    .busy      (busyP)
  );

  neuron_acc_ctrl #(.N_TERMS(NT), .ACT_RELU(1'b1)) dutR (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (inReadyR),
    .out_valid (outValidR),
    .out_data  (outDataR),
    .out_sat   (outSatR),
    .out_ready (out_ready),
    .busy      (busyR)
  );

  // Starts an evaluation and feeds four terms, optionally dropping in_valid for
  // 'gap' FETCH cycles after the second term. Returns at the first negedge with
  // out_valid high; latency counts clock edges after the start edge (-1 = timeout).
  task automatic runEval(input logic signed [16:0] b,
                         input logic signed [7:0] t0, input logic signed [7:0] t1,
                         input logic signed [7:0] t2, input logic signed [7:0] t3,
                         input int gap,
                         output int latency, output int accepted, output int gapReadyLow);
    logic signed [7:0] terms [4];
    int  idx;
    int  gapLeft;
    bit  gapStarted;
    bit  hs;
    terms[0] = t0; terms[1] = t1; terms[2] = t2; terms[3] = t3;
    idx = 0; gapLeft = gap; gapStarted = 1'b0;
    latency = -1; accepted = 0; gapReadyLow = 0;
    @(negedge clk);
    start = 1'b1; bias = b; in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (outValidP) begin
        latency = cyc;
        break;
      end
      if (accepted == 2 && gapLeft > 0) begin
        in_valid = 1'b0;
        if (inReadyP) begin
          gapStarted = 1'b1;
          gapLeft--;
        end else if (gapStarted) begin
          gapReadyLow++;
        end
      end else begin
        in_valid = 1'b1;
        if (idx < 4) in_data = terms[idx];
        else         in_data = 8'h55;
      end
      hs = in_valid && inReadyP;
      @(posedge clk);
      if (hs) begin
        accepted++;
        idx++;
      end
    end
  endtask

  task automatic finishOut();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    vectors++; if (inReadyP !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", inReadyP); end
    vectors++; if (outValidP !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", outValidP); end
    vectors++; if (outDataP !== 17'sd0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %0d, expected 0", outDataP); end
    vectors++; if (outSatP !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_sat: got %b, expected 0", outSatP); end
    vectors++; if (busyP !== 1'b0 || busyR !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b/%b, expected 0/0", busyP, busyR); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, acc, gl;
    runEval(17'sd100, 8'sd10, -8'sd20, 8'sd30, 8'sd5, 0, lat, acc, gl);
    vectors++; if (lat !== 2 * NT) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d edges, expected %0d", lat, 2 * NT); end
    vectors++; if (outDataP !== 17'sd125) begin miscompares++; $display("[TB] FAIL basic_data: got %0d, expected 125", outDataP); end
    vectors++; if (outDataR !== 17'sd125) begin miscompares++; $display("[TB] FAIL basic_data_relu: got %0d, expected 125", outDataR); end
    vectors++; if (outSatP !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_sat: got %b, expected 0", outSatP); end
    vectors++; if (acc !== NT) begin miscompares++; $display("[TB] FAIL basic_accepted: got %0d, expected %0d", acc, NT); end
    finishOut();
  endtask

  task automatic test_pos_sat();
    int lat, acc, gl;
    runEval(17'sd65500, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 0, lat, acc, gl);
    vectors++; if (lat !== 2 * NT) begin miscompares++; $display("[TB] FAIL possat_latency: got %0d, expected %0d", lat, 2 * NT); end
    vectors++; if (outDataP !== 17'sd65535) begin miscompares++; $display("[TB] FAIL possat_data: got %0d, expected 65535", outDataP); end
    vectors++; if (outSatP !== 1'b1) begin miscompares++; $display("[TB] FAIL possat_sat: got %b, expected 1", outSatP); end
    vectors++; if (outSatR !== 1'b1 || outDataR !== 17'sd65535) begin miscompares++; $display("[TB] FAIL possat_relu: got %0d/%b, expected 65535/1", outDataR, outSatR); end
    finishOut();
  endtask

  task automatic test_neg_relu();
    int lat, acc, gl;
    runEval(-17'sd10, 8'sd1, 8'sd2, 8'sd3, 8'sd0, 0, lat, acc, gl);
    vectors++; if (lat !== 2 * NT) begin miscompares++; $display("[TB] FAIL negrelu_latency: got %0d, expected %0d", lat, 2 * NT); end
    vectors++; if (outDataR !== 17'sd0) begin miscompares++; $display("[TB] FAIL negrelu_data_relu: got %0d, expected 0", outDataR); end
    vectors++; if (outDataP !== -17'sd4) begin miscompares++; $display("[TB] FAIL negrelu_data_pass: got %0d, expected -4", outDataP); end
    vectors++; if (outSatP !== 1'b0 || outSatR !== 1'b0) begin miscompares++; $display("[TB] FAIL negrelu_sat: got %b/%b, expected 0/0", outSatP, outSatR); end
    finishOut();
  endtask

  task automatic test_neg_sat_stall();
    int lat, acc, gl;
    runEval(-17'sd65500, 8'h80, 8'h80, 8'h80, 8'h80, 3, lat, acc, gl);
    vectors++; if (lat !== 2 * NT + 3) begin miscompares++; $display("[TB] FAIL negsat_latency: got %0d, expected %0d", lat, 2 * NT + 3); end
    vectors++; if (outDataP !== -17'sd65536) begin miscompares++; $display("[TB] FAIL negsat_data: got %0d, expected -65536", outDataP); end
    vectors++; if (outSatP !== 1'b1) begin miscompares++; $display("[TB] FAIL negsat_sat: got %b, expected 1", outSatP); end
    vectors++; if (outDataR !== 17'sd0 || outSatR !== 1'b1) begin miscompares++; $display("[TB] FAIL negsat_relu: got %0d/%b, expected 0/1", outDataR, outSatR); end
    vectors++; if (acc !== NT) begin miscompares++; $display("[TB] FAIL negsat_accepted: got %0d, expected %0d", acc, NT); end
    vectors++; if (gl !== 0) begin miscompares++; $display("[TB] FAIL negsat_gap_ready: got %0d low cycles, expected 0", gl); end
    finishOut();
  endtask

  task automatic test_backpressure();
    int lat, acc, gl;
    int extra;
    runEval(17'sd1000, -8'sd1, -8'sd2, -8'sd3, -8'sd4, 0, lat, acc, gl);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      start = (i == 2);
      bias  = 17'sd7;
      if (in_valid && inReadyP) extra++;
      vectors++;
      if (outValidP !== 1'b1 || outDataP !== 17'sd990 || inReadyP !== 1'b0 || busyP !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b data=%0d ready=%b busy=%b, expected 1/990/0/1",
                 i, outValidP, outDataP, inReadyP, busyP);
      end
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("[TB] FAIL bp_extra_terms: got %0d, expected 0", extra); end
    start = 1'b0;
    finishOut();
    @(negedge clk);
    vectors++; if (busyP !== 1'b0 || outValidP !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_idle: got busy=%b valid=%b, expected 0/0", busyP, outValidP); end
    @(negedge clk);
    vectors++; if (busyP !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_no_restart: got busy=%b, expected 0", busyP); end
  endtask

  task automatic test_reset_midop();
    int  lat, acc, gl;
    int  got;
    bit  hs;
    got = 0;
    @(negedge clk);
    start = 1'b1; bias = 17'sd500; in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'sd7;
      hs = inReadyP;
      @(posedge clk);
      if (hs) got++;
    end
    vectors++; if (got !== 2) begin miscompares++; $display("[TB] FAIL midop_terms_before_reset: got %0d, expected 2", got); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (busyP !== 1'b0 || inReadyP !== 1'b0 || outValidP !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_reset_ctrl: got busy=%b ready=%b valid=%b, expected 0/0/0", busyP, inReadyP, outValidP); end
    vectors++; if (outDataP !== 17'sd0 || outSatP !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_reset_data: got %0d/%b, expected 0/0", outDataP, outSatP); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    runEval(17'sd0, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 0, lat, acc, gl);
    vectors++; if (outDataP !== 17'sd4 || outDataR !== 17'sd4) begin miscompares++; $display("[TB] FAIL midop_rerun_data: got %0d/%0d, expected 4/4", outDataP, outDataR); end
    vectors++; if (outSatP !== 1'b0 || lat !== 2 * NT) begin miscompares++; $display("[TB] FAIL midop_rerun_sat_lat: got sat=%b lat=%0d, expected 0/%0d", outSatP, lat, 2 * NT); end
    finishOut();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_relu();
    test_neg_sat_stall();
    test_backpressure();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
